// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// The initiator uses the master modport; the responder uses the slave modport.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with RISC-V byte/half/word access and fixed wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus,
   output logic              busy
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int ADDR_W = IDX_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [2:0]          f3_q;

   logic [31:0]         mem_q [DEPTH_WORDS];
   logic [31:0]         rd_q;

   logic                accept;
   logic                enter_resp;
   logic                cur_wr;
   logic [ADDR_W-1:0]   cur_addr;
   logic [31:0]         cur_wdata;
   logic [2:0]          cur_f3;
   logic [IDX_W-1:0]    cur_idx;
   logic                cur_f3_ok, lat_f3_ok;
   logic                mis_cur, mis_lat;
   logic                cur_ok, lat_ok;
   logic [3:0]          be;
   logic [7:0]          wlane [4];
   logic                unused_addr_bits;

   assign unused_addr_bits = ^bus.req_addr[31:ADDR_W];

   function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
      if (wr)
         return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      else
         return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
   endfunction

   assign accept = bus.req_valid && (state_q == S_IDLE);

   // With zero wait states the memory op happens on the acceptance edge,
   // so the live request fields are used instead of the latched copies.
   assign cur_wr    = (state_q == S_IDLE) ? bus.req_write          : wr_q;
   assign cur_addr  = (state_q == S_IDLE) ? bus.req_addr[ADDR_W-1:0] : addr_q;
   assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata          : wdata_q;
   assign cur_f3    = (state_q == S_IDLE) ? bus.req_funct3         : f3_q;
   assign cur_idx   = cur_addr[ADDR_W-1:2];

   assign cur_f3_ok = f3_legal(cur_wr, cur_f3);
   assign lat_f3_ok = f3_legal(wr_q, f3_q);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis_cur = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
   assign mis_lat = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
   assign mis_cur = 1'b0;
   assign mis_lat = 1'b0;
`endif

   assign cur_ok = cur_f3_ok && !mis_cur;
   assign lat_ok = lat_f3_ok && !mis_lat;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign be[gi] = cur_wr && cur_ok &&
                         ((cur_f3 == 3'b010) ||
                          ((cur_f3 == 3'b001) && (cur_addr[1] == 1'(gi / 2))) ||
                          ((cur_f3 == 3'b000) && (cur_addr[1:0] == 2'(gi))));
         assign wlane[gi] = (cur_f3 == 3'b000) ? cur_wdata[7:0] :
                            (cur_f3 == 3'b001) ? cur_wdata[(gi % 2) * 8 +: 8] :
                                                 cur_wdata[gi * 8 +: 8];
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
      end else if (accept) begin
         wr_q    <= bus.req_write;
         addr_q  <= bus.req_addr[ADDR_W-1:0];
         wdata_q <= bus.req_wdata;
         f3_q    <= bus.req_funct3;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);

   // Byte-enabled write and registered read share the commit edge; storage is never reset.
   always_ff @(posedge clk) begin
      if (!reset && enter_resp) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[cur_idx][b * 8 +: 8] <= wlane[b];
         end
         rd_q <= mem_q[cur_idx];
      end
   end

   // Output logic
   always_comb begin
      bus.req_ready = (state_q == S_IDLE);
      bus.rsp_valid = (state_q == S_RESP);
      busy          = (state_q != S_IDLE);
      bus.rsp_err   = (state_q == S_RESP) && !lat_ok;
      bus.rsp_rdata = '0;
      if ((state_q == S_RESP) && lat_ok && !wr_q) begin
         case (f3_q)
            3'b000:  bus.rsp_rdata = {{24{rd_q[{addr_q[1:0], 3'b111}]}}, rd_q[{addr_q[1:0], 3'b000} +: 8]};
            3'b001:  bus.rsp_rdata = addr_q[1] ? {{16{rd_q[31]}}, rd_q[31:16]}
                                               : {{16{rd_q[15]}}, rd_q[15:0]};
            3'b010:  bus.rsp_rdata = rd_q;
            3'b100:  bus.rsp_rdata = {24'd0, rd_q[{addr_q[1:0], 3'b000} +: 8]};
            3'b101:  bus.rsp_rdata = addr_q[1] ? {16'd0, rd_q[31:16]} : {16'd0, rd_q[15:0]};
            default: bus.rsp_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance A (WAIT_CYCLES=2) and instance B (WAIT_CYCLES=0).
// Drivers push expected responses; a negedge monitor pops and checks latency, data, error and hold stability.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        busy_a, busy_b;
   logic        drv_valid, drv_write, drv_rsp_ready;
   logic [31:0] drv_addr, drv_wdata;
   logic [2:0]  drv_f3;
   int          sel;

   dmem_responder_if ifa ();
   dmem_responder_if ifb ();

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a)
   );
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b)
   );

   assign ifa.req_valid  = drv_valid && (sel == 0);
   assign ifa.req_write  = drv_write;
   assign ifa.req_addr   = drv_addr;
   assign ifa.req_wdata  = drv_wdata;
   assign ifa.req_funct3 = drv_f3;
   assign ifa.rsp_ready  = drv_rsp_ready && (sel == 0);
   assign ifb.req_valid  = drv_valid && (sel == 1);
   assign ifb.req_write  = drv_write;
   assign ifb.req_addr   = drv_addr;
   assign ifb.req_wdata  = drv_wdata;
   assign ifb.req_funct3 = drv_f3;
   assign ifb.rsp_ready  = drv_rsp_ready && (sel == 1);

   logic [1:0]  m_valid, m_ready, m_err, m_busy;
   logic [31:0] m_rdata [2];
   assign m_valid = {ifb.rsp_valid, ifa.rsp_valid};
   assign m_ready = {ifb.req_ready, ifa.req_ready};
   assign m_err   = {ifb.rsp_err, ifa.rsp_err};
   assign m_busy  = {busy_b, busy_a};
   assign m_rdata[0] = ifa.rsp_rdata;
   assign m_rdata[1] = ifb.rsp_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
      int          tag;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int tag      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: first cycle of rsp_valid pops the scoreboard; later cycles check the response holds.
   logic [1:0]  prev_v = 2'b00;
   logic [31:0] hold_rdata [2];
   logic [1:0]  hold_err;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (m_valid[k] && !prev_v[k]) begin
            exp_t e;
            bit   got;
            got = 1'b0;
            if (k == 0 && q_a.size() > 0) begin
               e = q_a.pop_front();
               got = 1'b1;
            end else if (k == 1 && q_b.size() > 0) begin
               e = q_b.pop_front();
               got = 1'b1;
            end
            if (!got) begin
               check("unexpected response", 32'd1, 32'd0);
            end else begin
               check("rsp latency", 32'(cyc - e.acc), 32'(e.lat));
               check("rsp_rdata", m_rdata[k], e.rdata);
               check("rsp_err", {31'd0, m_err[k]}, {31'd0, e.err});
               $display("txn dut%0d tag %0d: rdata 0x%08h err %0d latency %0d",
                        k, e.tag, m_rdata[k], m_err[k], cyc - e.acc);
            end
            hold_rdata[k] <= m_rdata[k];
            hold_err[k]   <= m_err[k];
         end else if (m_valid[k]) begin
            check("held rsp_rdata", m_rdata[k], hold_rdata[k]);
            check("held rsp_err", {31'd0, m_err[k]}, {31'd0, hold_err[k]});
            check("req_ready in RESP", {31'd0, m_ready[k]}, 32'd0);
         end
         prev_v[k] <= m_valid[k];
      end
   end

   task automatic do_req(input int which, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int hold, input bit abort);
      exp_t e;
      int   n;
      @(negedge clk);
      sel = which; drv_write = wr; drv_addr = addr; drv_wdata = wdata; drv_f3 = f3;
      drv_valid = 1'b1;
      n = 0;
      while (!m_ready[which] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_ready[which]) begin
         check("req_ready wait", 32'd0, 32'd1);
         drv_valid = 1'b0;
         return;
      end
      e.rdata = exp_rdata; e.err = exp_err; e.acc = cyc;
      e.lat = (which == 0) ? 3 : 1; e.tag = tag;
      tag++;
      if (!abort) begin
         if (which == 0) q_a.push_back(e);
         else            q_b.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      drv_valid = 1'b0;
      if (abort) begin
         check("no rsp before reset", {31'd0, m_valid[which]}, 32'd0);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("busy after abort", {31'd0, m_busy[which]}, 32'd0);
         check("req_ready after abort", {31'd0, m_ready[which]}, 32'd1);
         repeat (6) @(negedge clk);
         check("no rsp after abort", {31'd0, m_valid[which]}, 32'd0);
         $display("txn dut%0d tag %0d: aborted by reset", which, e.tag);
         return;
      end
      n = 0;
      while (!m_valid[which] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_valid[which]) begin
         check("rsp_valid wait", 32'd0, 32'd1);
         return;
      end
      repeat (hold) @(negedge clk);
      drv_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("idle after handshake", {31'd0, m_busy[which]}, 32'd0);
      check("req_ready after handshake", {31'd0, m_ready[which]}, 32'd1);
      @(negedge clk);
      drv_rsp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drv_valid = 1'b0; drv_write = 1'b0; drv_rsp_ready = 1'b0;
      drv_addr = '0; drv_wdata = '0; drv_f3 = '0; sel = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
      check("reset rsp_rdata", ifa.rsp_rdata, 32'd0);
      check("reset rsp_err", {31'd0, ifa.rsp_err}, 32'd0);
      check("reset busy", {31'd0, busy_a}, 32'd0);
      check("reset req_ready", {31'd0, ifa.req_ready}, 32'd1);
      check("reset busy b", {31'd0, busy_b}, 32'd0);

      // which, wr, addr, wdata, funct3, expected rdata, expected err, hold, abort
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0, 1'b0);
      do_req(0, 1'b1, 32'h11, 32'h80,       3'b000, 32'h0,        1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h11, 32'h0,        3'b100, 32'h00000080, 1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0, 5, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_req(0, 1'b0, 32'h13, 32'h0,        3'b001, 32'h0,        1'b1, 0, 1'b0);
`else
      do_req(0, 1'b0, 32'h13, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 0, 1'b0);
`endif
      do_req(0, 1'b0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 1'b0, 0, 1'b0);
      do_req(0, 1'b1, 32'h12, 32'h1234ABCD, 3'b001, 32'h0,        1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hABCD80EF, 1'b0, 0, 1'b0);
      do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 32'h0,        1'b1, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0,        3'b010, 32'hABCD80EF, 1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h10, 32'h0,        3'b110, 32'h0,        1'b1, 0, 1'b0);
      do_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 0, 1'b0);
      do_req(0, 1'b1, 32'h20, 32'h12345678, 3'b010, 32'h0,        1'b0, 0, 1'b1);
      do_req(0, 1'b0, 32'h20, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 0, 1'b0);
      do_req(0, 1'b1, 32'h100, 32'h55AA1234, 3'b010, 32'h0,       1'b0, 0, 1'b0);
      do_req(0, 1'b0, 32'h000, 32'h0,       3'b010, 32'h55AA1234, 1'b0, 0, 1'b0);

      do_req(1, 1'b0, 32'h0,  32'h0,        3'b011, 32'h0,        1'b1, 0, 1'b0);
      do_req(1, 1'b1, 32'h4,  32'h000000FF, 3'b010, 32'h0,        1'b0, 0, 1'b0);
      do_req(1, 1'b0, 32'h4,  32'h0,        3'b000, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
      do_req(1, 1'b0, 32'h4,  32'h0,        3'b001, 32'h000000FF, 1'b0, 0, 1'b0);
      do_req(1, 1'b0, 32'h4,  32'h0,        3'b010, 32'h000000FF, 1'b0, 2, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard a drained", 32'(q_a.size()), 32'd0);
      check("scoreboard b drained", 32'(q_b.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 20000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit storage words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_funct3  input  3  RISC-V load/store funct3.
REQ-011 SHALL have port rsp_valid  output  1  a response is presented.
REQ-012 SHALL have port rsp_ready  input  1  the initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  the request was rejected.
REQ-015 SHALL have port busy  output  1  the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1; acceptance latches write, addr, wdata, and funct3.
REQ-018 SHALL on acceptance go IDLE->WAIT and load the wait counter with WAIT_CYCLES; when WAIT_CYCLES=0, SHALL go IDLE->RESP directly.
REQ-019 SHALL decrement the counter in WAIT and go WAIT->RESP on the cycle the counter reaches 1.
REQ-020 SHALL make the first rsp_valid=1 exactly 1+WAIT_CYCLES cycles after the acceptance edge.
REQ-021 SHALL hold rsp_valid, rsp_rdata, and rsp_err stable in RESP until rsp_ready=1, then go RESP->IDLE; rsp_ready outside RESP SHALL be ignored.
REQ-022 SHALL permit no new acceptance in the cycle RESP->IDLE occurs; back-to-back requests are spaced at least 2+WAIT_CYCLES cycles apart.
REQ-023 SHALL form the word index from req_addr[2 +: log2(DEPTH_WORDS)]; higher address bits are ignored (address wraps modulo 4*DEPTH_WORDS bytes).
REQ-024 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH are sign-extended, LBU/LHU are zero-extended; the byte lane is addr[1:0] and the halfword lane is addr[1].
REQ-025 SHALL decode stores as 000 SB, 001 SH, 010 SW; SB/SH modify only the addressed lanes and leave the other bytes of the word unchanged.
REQ-026 SHALL commit a store on the WAIT/IDLE->RESP transition edge, so a load accepted afterwards observes the new data.
REQ-027 SHALL treat any other funct3 (load 011/110/111, store 011..111) as illegal: memory unchanged, rsp_rdata=0, rsp_err=1.

Reset
REQ-028 SHALL on reset set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and req_ready=1 in the following cycle.
REQ-029 SHALL on reset asserted mid-WAIT abort the transaction: no store is committed and no response is issued.
REQ-030 SHALL not clear storage contents on reset; a store already committed before reset remains.

Configuration
REQ-031 SHALL support macro DMEM_MISALIGN_TRAP_EN; when it is defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL leave memory unchanged and respond with rsp_rdata=0 and rsp_err=1, with the normal latency.
REQ-032 SHALL, when DMEM_MISALIGN_TRAP_EN is not defined, ignore unused low address bits (halfword uses addr[1] only, word ignores addr[1:0]) and keep rsp_err=0 for all legal funct3 values.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 3 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: after REQ-033, SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready 0 throughout, and IDLE on the edge after rsp_ready=1.
REQ-036 SHALL cover: SW 0x20 data 0x12345678, reset pulsed during WAIT, then LW 0x20 -> no response before reset, and the old contents (not 0x12345678) read back.
REQ-037 SHALL cover: LH addr 0x13 -> with DMEM_MISALIGN_TRAP_EN, err=1 and rdata 0; without it, err=0 and the upper halfword of word 0x10 is returned, sign-extended.
REQ-038 SHALL cover: WAIT_CYCLES=0, load funct3 011 -> rsp_valid on the cycle after acceptance with err=1 and rdata 0; DEPTH_WORDS=64 with SW 0x100 then LW 0x000 -> same word (wrap-around).
